// File: rtl/key_cond_pkg.sv
// ---------------------------------------------------------------------------
// key_cond_pkg : shared defaults and width helpers for the key conditioner
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package key_cond_pkg;

  localparam int c_CHANNELS        = 8;
  localparam int c_SYNC_STAGES     = 2;
  localparam int c_DEBOUNCE_CYCLES = 4;

  // Debounce counter width, never narrower than one bit.
  function automatic int cnt_width(input int dc);
    return ($clog2(dc + 1) < 1) ? 1 : $clog2(dc + 1);
  endfunction

  function automatic int count_width(input int ch);
    return $clog2(ch + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch : one key channel - synchroniser, debounce counter,
//                   registered level and press/release pulses
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = c_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_sample_en,
  output logic o_level,
  output logic o_level_nxt,
  output logic o_press,
  output logic o_release
);

  localparam int            CW     = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;

  logic                   w_sync_out;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_level_nxt;
  logic                   w_press_nxt;
  logic                   w_release_nxt;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    if (i_sample_en) begin
      if (w_sync_out == r_level) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == c_LAST) begin
        // Commit: level, counter clear and pulse all land on the same edge.
        w_level_nxt   = w_sync_out;
        w_cnt_nxt     = '0;
        w_press_nxt   = w_sync_out;
        w_release_nxt = ~w_sync_out;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;
  assign o_press     = r_press;
  assign o_release   = r_release;

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner : multi-channel piano key conditioner with held-key count
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int CHANNELS        = c_CHANNELS,
  parameter int SYNC_STAGES     = c_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CHANNELS-1:0]                  raw_keys,
  input  logic                                 sample_en,
  output logic [CHANNELS-1:0]                  key_level,
  output logic [CHANNELS-1:0]                  key_press,
  output logic [CHANNELS-1:0]                  key_release,
  output logic [count_width(CHANNELS)-1:0]     active_count
);

  localparam int CNT_W = count_width(CHANNELS);

  logic [CHANNELS-1:0] w_level_nxt;
  logic [CNT_W-1:0]    w_pop;
  logic [CNT_W-1:0]    r_count;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_raw       (raw_keys[g]),
      .i_sample_en (sample_en),
      .o_level     (key_level[g]),
      .o_level_nxt (w_level_nxt[g]),
      .o_press     (key_press[g]),
      .o_release   (key_release[g])
    );
  end

  // Count the next-state levels so the count moves on the same edge as key_level.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pop = w_pop + CNT_W'(w_level_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_pop;
    end
  end

  assign active_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner : scoreboard bench for key_conditioner (default params)
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_conditioner;

  localparam int CH = 8;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int CW = $clog2(CH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw_keys = '0;
  logic          sample_en = 1'b0;
  logic [CH-1:0] key_level;
  logic [CH-1:0] key_press;
  logic [CH-1:0] key_release;
  logic [CW-1:0] active_count;

  key_conditioner #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_keys     (raw_keys),
    .sample_en    (sample_en),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pops     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    int            count;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a key's level flips once DC consecutive qualified samples
  // of the input (as seen SS edges late) disagree with it.
  logic [CH-1:0] m_level;
  int            m_run[CH];
  logic [CH-1:0] m_hist[$];

  always @(posedge clk) begin
    exp_t          e;
    logic [CH-1:0] seen;
    e.press = '0;
    e.rel   = '0;
    if (reset) begin
      m_level = '0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
      m_hist.delete();
      for (int i = 0; i < SS; i++) m_hist.push_back('0);
    end else begin
      seen = m_hist.pop_front();
      m_hist.push_back(raw_keys);
      if (sample_en) begin
        for (int i = 0; i < CH; i++) begin
          if (seen[i] == m_level[i]) begin
            m_run[i] = 0;
          end else begin
            m_run[i]++;
            if (m_run[i] == DC) begin
              m_level[i] = seen[i];
              m_run[i]   = 0;
              if (seen[i]) e.press[i] = 1'b1;
              else         e.rel[i]   = 1'b1;
            end
          end
        end
      end
    end
    e.level = m_level;
    e.count = $countones(m_level);
    exp_q.push_back(e);
    pushes++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pops++;
      check("key_level",    32'(key_level),    32'(e.level));
      check("key_press",    32'(key_press),    32'(e.press));
      check("key_release",  32'(key_release),  32'(e.rel));
      check("active_count", 32'(active_count), 32'(e.count));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    cyc(3);
    reset     = 1'b0;
    sample_en = 1'b1;
    cyc(20);

    // Step on key 3: level must appear after SS+DC edges.
    raw_keys[3] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (key_level[3] === 1'b1) lat = k;
    end
    check("latency_key3", 32'(lat), 32'(SS + DC));
    cyc(5);

    // Glitch of DC-1 samples is rejected, DC samples commit.
    raw_keys[0] = 1'b1; cyc(DC - 1);
    raw_keys[0] = 1'b0; cyc(10);
    raw_keys[0] = 1'b1; cyc(DC);
    raw_keys[0] = 1'b0; cyc(14);

    // Sparse qualifier on key 5.
    for (int k = 0; k < 160; k++) begin
      sample_en   = (k % 10 == 0);
      raw_keys[5] = (k < 80);
      @(negedge clk);
    end

    sample_en = 1'b1;
    raw_keys  = '0;
    cyc(10);

    // Chord, then simultaneous release of 2 and press of 7.
    raw_keys[1] = 1'b1; raw_keys[2] = 1'b1; raw_keys[6] = 1'b1;
    cyc(10);
    raw_keys[2] = 1'b0; raw_keys[7] = 1'b1;
    cyc(10);
    raw_keys = '0;
    cyc(10);

    // Reset while key 4 is held and a release count is half done.
    raw_keys[4] = 1'b1; cyc(10);
    raw_keys[4] = 1'b0; cyc(SS + DC / 2);
    reset = 1'b1; cyc(1);
    reset = 1'b0;
    raw_keys[4] = 1'b1; cyc(12);

    // Randomised traffic.
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 7) == 0) raw_keys[i] = ~raw_keys[i];
      sample_en = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    cyc(5);

    @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(pops), 32'(pushes - 1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Multi-channel input conditioner for piano key switches, one channel per key.
- Each channel synchronises its raw key input and debounces it with a qualified-sample counter.
- Each channel outputs a clean level plus single-cycle press and release pulses.
- Sits between the key-switch pins and the note/tone logic; also reports how many keys are currently held.

Parameters:
- CHANNELS, 8, number of independent key channels (>=1)
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)
- DEBOUNCE_CYCLES, 4, consecutive differing qualified samples required to commit a level change (>=1)

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- raw_keys  input  CHANNELS  asynchronous raw key levels, 1 = pressed
- sample_en  input  1  debounce sample qualifier (e.g. 1 kHz tick); counters advance only when high
- key_level  output  CHANNELS  debounced key state, registered
- key_press  output  CHANNELS  one-cycle pulse when key_level[i] commits 0->1
- key_release  output  CHANNELS  one-cycle pulse when key_level[i] commits 1->0
- active_count  output  $clog2(CHANNELS+1)  number of bits set in key_level, registered

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset:
  - Sync chains, key_level, counters, key_press, key_release and active_count all clear to 0 on the next posedge with reset high.
  - Reset mid-debounce discards the partial count.
  - No pulse is generated by reset itself, even if key_level was 1.
- Synchroniser:
  - SYNC_STAGES-deep shift chain per channel, clocked every cycle regardless of sample_en.
  - sync_out[i] is the last stage.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1), min 1 bit:
  - sample_en=0: counter, key_level and active_count hold; key_press and key_release are 0.
  - sample_en=1 and sync_out==key_level: counter clears to 0.
  - sample_en=1, sync_out!=key_level, counter<DEBOUNCE_CYCLES-1: counter increments.
  - sample_en=1, sync_out!=key_level, counter==DEBOUNCE_CYCLES-1: key_level<=sync_out, counter<=0, and the matching pulse is asserted in the same edge.
- Pulses:
  - key_press/key_release are registered and high for exactly one cycle, coincident with the key_level change.
  - Both are never high together on one channel.
- Latency:
  - With sample_en tied high, a clean raw step before edge 0 makes key_level change at edge SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. the (SYNC_STAGES+DEBOUNCE_CYCLES)-th edge.
  - With sample_en sparse, latency is SYNC_STAGES edges plus DEBOUNCE_CYCLES qualified samples.
- Glitch rejection: a difference lasting fewer than DEBOUNCE_CYCLES consecutive qualified samples produces no change or pulse; any agreeing sample restarts the count.
- DEBOUNCE_CYCLES=1: the first differing qualified sample commits.
- active_count:
  - Registered popcount of the next-state key_level, so it updates in the same edge as key_level.
  - Range 0..CHANNELS; multiple simultaneous commits (press and release on different channels) are all reflected in the same edge.
- Channels are fully independent; simultaneous events on any subset behave per channel.

Decomposition:
- Package key_cond_pkg:
  - Function returning counter width max(1,$clog2(DEBOUNCE_CYCLES+1)).
  - Function returning count width $clog2(CHANNELS+1).
  - Default parameter constants.
- Sub-module key_debounce_ch: one channel (sync chain, counter, level, press/release); instantiated CHANNELS times in a generate loop.
- Top level holds only the generate loop and the registered popcount.

Test Plan:
- Reset release, all raw_keys=0, sample_en=1, 20 cycles -> key_level=0, no pulses, active_count=0 throughout.
- Defaults, sample_en=1, raw_keys[3] 0->1 before edge 0 and held -> key_level[3]=1 and key_press[3]=1 at edge 5 only; active_count=1 at edge 5.
- raw_keys[0] high for 3 synced cycles then low, sample_en=1 -> no change on key_level[0], no pulse; repeat with 4 cycles -> commit and press pulse.
- sample_en pulsed 1-in-10 cycles, raw_keys[5] held high -> commit on the 4th qualified sample after sync; counter holds between ticks; release later gives a single key_release[5] pulse.
- Keys 1,2,6 pressed together, then 2 released while 7 pressed in the same cycle, sample_en=1 -> active_count 0->3, then stays 3 in the same edge where key_release[2] and key_press[7] both assert.
- Reset asserted with key_level[4]=1 and a half-complete count on channel 4 -> next edge: all outputs 0, no release pulse; after reset, debounce restarts from count 0.
